// File: rtl/prog_timer.sv
// Programmable tick/timeout source: prescaled counter with one-shot or periodic
// mode, pause/resume, abort, restart-on-start and a completed-period counter.
module prog_timer #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   n_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               pause_i,
  output logic [WIDTH-1:0]   curr_time_q,
  output logic               curr_end_q,
  output logic               busy_q,
  output logic [WIDTH-1:0]   periods_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   n_q;
  logic [PRESC_W-1:0] presc_q;
  logic               mode_q;
  logic [PRESC_W-1:0] pc_q;

  logic [WIDTH-1:0]   last_time;
  logic               active;

  assign last_time = n_q - WIDTH'(1);
  assign active    = (state_q != IDLE);

  // Leaving PAUSED counts in the same cycle, so a pause of k cycles delays the end by k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      presc_q     <= '0;
      mode_q      <= 1'b0;
      pc_q        <= '0;
      curr_time_q <= '0;
      curr_end_q  <= 1'b0;
      busy_q      <= 1'b0;
      periods_q   <= '0;
    end else begin
      curr_end_q <= 1'b0;
      if (stop_i) begin
        state_q     <= IDLE;
        curr_time_q <= '0;
        pc_q        <= '0;
        busy_q      <= 1'b0;
      end else if (start_i && (n_i != '0)) begin
        state_q     <= RUNNING;
        n_q         <= n_i;
        presc_q     <= presc_i;
        mode_q      <= mode_i;
        curr_time_q <= '0;
        pc_q        <= '0;
        periods_q   <= '0;
        busy_q      <= 1'b1;
      end else if (active) begin
        if (pause_i) begin
          state_q <= PAUSED;
        end else begin
          state_q <= RUNNING;
          if (pc_q == presc_q) begin
            pc_q <= '0;
            if (curr_time_q == last_time) begin
              curr_end_q  <= 1'b1;
              curr_time_q <= '0;
              periods_q   <= periods_q + WIDTH'(1);
              if (!mode_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              curr_time_q <= curr_time_q + WIDTH'(1);
            end
          end else begin
            pc_q <= pc_q + PRESC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer (WIDTH=4 so period wrap is reachable):
// stimulus pushes expected end pulses, a monitor pops them on each curr_end_q.
module tb_prog_timer;

  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  n_i;
  logic [PW-1:0] presc_i;
  logic          mode_i;
  logic          start_i;
  logic          stop_i;
  logic          pause_i;
  logic [W-1:0]  curr_time_q;
  logic          curr_end_q;
  logic          busy_q;
  logic [W-1:0]  periods_q;

  typedef struct {
    int cyc;
    int periods;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  prog_timer #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .n_i        (n_i),
    .presc_i    (presc_i),
    .mode_i     (mode_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .pause_i    (pause_i),
    .curr_time_q(curr_time_q),
    .curr_end_q (curr_end_q),
    .busy_q     (busy_q),
    .periods_q  (periods_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every end pulse must match the oldest expected (edge number, period count).
  always @(negedge clk) begin
    if (rst_n && curr_end_q) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL end_pulse_unexpected: pulse at cycle %0d periods %0d, required no pulse",
                 cyc, periods_q);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc != mon_e.cyc || int'(periods_q) != mon_e.periods) begin
          errors++;
          $display("[TB] FAIL end_pulse: got cycle %0d periods %0d, required cycle %0d periods %0d",
                   cyc, periods_q, mon_e.cyc, mon_e.periods);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int n, input int p, input logic m,
                               input logic st, input logic sp);
    n_i     = n[W-1:0];
    presc_i = p[PW-1:0];
    mode_i  = m;
    start_i = st;
    stop_i  = sp;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  initial begin
    int e;
    rst_n   = 1'b0;
    n_i     = '0;
    presc_i = '0;
    mode_i  = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    pause_i = 1'b0;

    repeat (2) tick();
    checkOutput("reset_time", curr_time_q, 0);
    checkOutput("reset_end", curr_end_q, 0);
    checkOutput("reset_busy", busy_q, 0);
    checkOutput("reset_periods", periods_q, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] reset mid-count");
    applyStimulus(10, 0, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("midcount_time", curr_time_q, 4);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_time", curr_time_q, 0);
    checkOutput("async_reset_busy", busy_q, 0);
    checkOutput("async_reset_end", curr_end_q, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();

    $display("[TB] one-shot n=5 p=0");
    applyStimulus(5, 0, 1'b0, 1'b1, 1'b0);
    e = cyc;
    sb_q.push_back('{e + 5, 1});
    checkOutput("oneshot_start_time", curr_time_q, 0);
    checkOutput("oneshot_start_busy", busy_q, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("oneshot_time", curr_time_q, i);
    end
    tick();
    checkOutput("oneshot_end", curr_end_q, 1);
    checkOutput("oneshot_busy_drop", busy_q, 0);
    checkOutput("oneshot_periods", periods_q, 1);
    tick();
    checkOutput("oneshot_end_cleared", curr_end_q, 0);

    $display("[TB] periodic n=3 p=2");
    applyStimulus(3, 2, 1'b1, 1'b1, 1'b0);
    e = cyc;
    sb_q.push_back('{e + 9, 1});
    sb_q.push_back('{e + 18, 2});
    sb_q.push_back('{e + 27, 3});
    repeat (2) tick();
    checkOutput("presc_hold_time", curr_time_q, 0);
    tick();
    checkOutput("presc_tick_time", curr_time_q, 1);
    repeat (24) tick();
    checkOutput("periodic_periods", periods_q, 3);
    checkOutput("periodic_busy", busy_q, 1);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_busy", busy_q, 0);
    checkOutput("stop_periods_held", periods_q, 3);

    $display("[TB] pause n=8 p=1");
    applyStimulus(8, 1, 1'b0, 1'b1, 1'b0);
    e = cyc;
    sb_q.push_back('{e + 22, 1});
    repeat (6) tick();
    checkOutput("prepause_time", curr_time_q, 3);
    pause_i = 1'b1;
    repeat (6) tick();
    checkOutput("paused_time", curr_time_q, 3);
    checkOutput("paused_busy", busy_q, 1);
    pause_i = 1'b0;
    repeat (9) tick();
    checkOutput("resumed_time", curr_time_q, 7);
    tick();
    checkOutput("pause_end_busy", busy_q, 0);

    $display("[TB] abort and restart");
    applyStimulus(2, 0, 1'b1, 1'b1, 1'b0);
    e = cyc;
    sb_q.push_back('{e + 2, 1});
    sb_q.push_back('{e + 4, 2});
    repeat (5) tick();
    checkOutput("preabort_time", curr_time_q, 1);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_busy", busy_q, 0);
    checkOutput("abort_time", curr_time_q, 0);
    checkOutput("abort_periods_held", periods_q, 2);
    repeat (3) tick();
    applyStimulus(10, 0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    applyStimulus(4, 0, 1'b0, 1'b1, 1'b0);
    e = cyc;
    sb_q.push_back('{e + 4, 1});
    checkOutput("restart_time", curr_time_q, 0);
    checkOutput("restart_busy", busy_q, 1);
    repeat (4) tick();
    checkOutput("restart_end_busy", busy_q, 0);
    repeat (8) tick();
    applyStimulus(6, 0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(6, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("stop_beats_start_busy", busy_q, 0);
    checkOutput("stop_beats_start_time", curr_time_q, 0);
    repeat (8) tick();

    $display("[TB] corners");
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_n_idle_busy", busy_q, 0);
    applyStimulus(3, 0, 1'b0, 1'b1, 1'b0);
    e = cyc;
    sb_q.push_back('{e + 3, 1});
    tick();
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("zero_n_running_time", curr_time_q, 2);
    checkOutput("zero_n_running_busy", busy_q, 1);
    tick();
    checkOutput("zero_n_oneshot_kept", busy_q, 0);
    applyStimulus(1, 0, 1'b1, 1'b1, 1'b0);
    e = cyc;
    for (int k = 1; k <= 20; k++) sb_q.push_back('{e + k, k % 16});
    repeat (16) tick();
    checkOutput("periods_wrap", periods_q, 0);
    checkOutput("n1_end_high", curr_end_q, 1);
    repeat (4) tick();
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("n1_stop_periods", periods_q, 4);
    checkOutput("n1_stop_end", curr_end_q, 0);
    repeat (2) tick();

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
